mmio_uart_tx: RTL and testbench
===============================

Name: mmio_uart_tx

Overview:
- Memory-mapped UART transmitter that responds on the cpu data port (data_addr / data_wdata / data_we / data_rdata).
- The cpu writes bytes into a small TX FIFO. An 8N1 serialiser drains the FIFO on a single tx line.
- Status and baud divisor are readable and writable. The top level muxes data_rdata from this block when hit is high, otherwise from simple_ram.

Parameters:
- BASE_ADDR, 32'h1000_0000, base of the 16-byte register window; bits [3:0] must be 0.
- FIFO_DEPTH, 4, TX FIFO entries; power of two, minimum 2.
- DEFAULT_DIV, 16'd868, reset value of BAUDDIV (clock cycles per bit).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- data_addr  input  32  cpu data address.
- data_wdata  input  32  cpu write data.
- data_we  input  4  per-byte write enable; bit i enables lane i.
- data_rdata  output  32  read data; combinational from data_addr.
- hit  output  1  combinational; high when data_addr[31:4] == BASE_ADDR[31:4].
- tx  output  1  serial line; idles high.

Behaviour:
Register map (offset = data_addr[3:0]; word-aligned; other offsets read 0 and ignore writes):
- 0x0 TXDATA: a write with data_we[0]=1 pushes data_wdata[7:0]. Reads return 0.
- 0x4 STATUS: bit0 busy (FSM not IDLE), bit1 full, bit2 empty, bit3 ovf (sticky). A write with data_we[0]=1 and data_wdata[3]=1 clears ovf.
- 0x8 BAUDDIV: bits [15:0]; lanes 0/1 written independently. A written value of 0 is stored as 1. Reads return {16'b0, div}.

General rules:
- Writes take effect on the rising clk edge when hit=1 and the relevant data_we bit is 1.
- data_rdata is 0 when hit=0.

Reset (asynchronous, immediate):
- tx=1, FIFO empty, ovf=0, div=DEFAULT_DIV, FSM=IDLE, bit counter and baud counter = 0.
- Reset mid-frame abandons the frame; tx returns high at once.

FIFO:
- Pointers are log2(FIFO_DEPTH)+1 bits wide; the extra MSB distinguishes full from empty. Pointers wrap modulo 2*FIFO_DEPTH.
- full and empty are judged on pre-edge state.
- A push while full is dropped and sets ovf, even if the FSM pops in the same cycle.
- A push and a pop in the same cycle, when not full and not empty, are both performed; the occupancy count is unchanged.

FSM states: IDLE, START, DATA, STOP.
- IDLE: if the FIFO is not empty, pop into an 8-bit shift register, load baud_cnt=div-1, go to START, and drive tx=0 from that edge.
  - A byte written into an empty FIFO at edge N is popped at edge N+1. tx falls after edge N+1.
- START: tx=0 for div cycles, then go to DATA with bit_idx=0.
- DATA: tx=shift[0] (LSB first) for div cycles per bit. The register shifts right at each bit boundary. After bit_idx=7, go to STOP.
- STOP: tx=1 for div cycles. At the end:
  - if the FIFO is not empty, pop and go directly to START (back-to-back frames, no idle gap);
  - otherwise go to IDLE.
- Baud counter: decrements each cycle and is reloaded with div-1 at every bit boundary (when it reaches 0). A BAUDDIV write mid-frame therefore takes effect at the next bit boundary.
- Frame length is exactly 10*div cycles.
- busy is 1 in START, DATA and STOP.

Decomposition:
- Package uart_pkg holds:
  - state enum/localparams S_IDLE=2'd0, S_START=2'd1, S_DATA=2'd2, S_STOP=2'd3;
  - register offsets OFF_TXDATA=4'h0, OFF_STATUS=4'h4, OFF_BAUDDIV=4'h8;
  - STATUS bit indices.
- One sub-module: sync_fifo (parameters WIDTH=8, DEPTH). Ports: push, din, pop, dout, full, empty; async active-high rst.
- Bus decode, registers and FSM stay in mmio_uart_tx.

Test Plan:
- Reset: assert rst mid-simulation -> tx=1, STATUS reads 32'h4 (empty), BAUDDIV reads DEFAULT_DIV within the same cycle.
- Single byte: BAUDDIV=4, write 8'hA5 to TXDATA at edge N -> tx low from N+1 for 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then stop high. busy clears at N+41.
- Back-to-back: div=2, write 8'h01, 8'h02, 8'h03 on consecutive cycles -> three 20-cycle frames with no idle gap; STATUS empty=1 only after the third pop.
- Overflow: div=100, FIFO_DEPTH=4, write 6 bytes on consecutive cycles -> 1 popped, 4 queued, the 6th dropped; STATUS=32'hB (ovf|full|busy). Writing 32'h8 to STATUS clears ovf -> STATUS reads 32'h3.
- BAUDDIV write 0 -> reads back 1; a frame then lasts 10 cycles. Changing div from 4 to 8 mid-DATA -> the current bit keeps 4 cycles, following bits take 8.
- Decode: accesses to BASE_ADDR+0x10 and to offset 0xC -> hit=0 or rdata=0 respectively, no FIFO push. Writes with data_we=4'b0010 to TXDATA -> ignored.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared encodings for the memory-mapped UART transmitter: FSM states,
// register offsets and STATUS bit positions.
package uart_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  localparam logic [3:0] OFF_TXDATA  = 4'h0;
  localparam logic [3:0] OFF_STATUS  = 4'h4;
  localparam logic [3:0] OFF_BAUDDIV = 4'h8;

  localparam int ST_BUSY  = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_EMPTY = 2;
  localparam int ST_OVF   = 3;

  // A divisor of zero would stall the baud counter, so it is stored as 1.
  function automatic logic [15:0] fix_div(input logic [15:0] d);
    return (d == 16'd0) ? 16'd1 : d;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with one extra pointer bit to tell full from empty.
// Pushes while full and pops while empty are ignored.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [AW:0]      wr_ptr, rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop && !empty) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: register decode, TX FIFO and
// serialiser FSM driving a single tx line.
module mmio_uart_tx
  import uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
  parameter int          FIFO_DEPTH  = 4,
  parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  input  logic [3:0]  data_we,
  output logic [31:0] data_rdata,
  output logic        hit,
  output logic        tx
);
  logic [3:0]  off;
  logic        wr_tx, wr_st, wr_div;
  logic        fifo_full, fifo_empty, pop;
  logic [7:0]  fifo_dout;
  logic        ovf;
  logic [15:0] div;
  logic        unused_bits;

  state_t      state, state_nx;
  logic [15:0] baud_cnt, baud_nx;
  logic [2:0]  bit_idx, bit_nx;
  logic [7:0]  shift, shift_nx;
  logic        bit_end, busy;

  assign hit    = (data_addr[31:4] == BASE_ADDR[31:4]);
  assign off    = data_addr[3:0];
  assign wr_tx  = hit && (off == OFF_TXDATA) && data_we[0];
  assign wr_st  = hit && (off == OFF_STATUS) && data_we[0];
  assign wr_div = hit && (off == OFF_BAUDDIV) && (data_we[1:0] != 2'b00);
  assign unused_bits = ^{data_wdata[31:16], data_we[3:2]};

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (wr_tx),
    .din   (data_wdata[7:0]),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf <= 1'b0;
      div <= DEFAULT_DIV;
    end else begin
      // A push into a full FIFO is lost even if the FSM pops this cycle.
      if (wr_tx && fifo_full)             ovf <= 1'b1;
      else if (wr_st && data_wdata[ST_OVF]) ovf <= 1'b0;
      if (wr_div)
        div <= fix_div({data_we[1] ? data_wdata[15:8] : div[15:8],
                        data_we[0] ? data_wdata[7:0]  : div[7:0]});
    end
  end

  assign busy = (state != S_IDLE);

  always_comb begin
    data_rdata = 32'd0;
    if (hit) begin
      case (off)
        OFF_STATUS:  data_rdata = {28'd0, ovf, fifo_empty, fifo_full, busy};
        OFF_BAUDDIV: data_rdata = {16'd0, div};
        default:     data_rdata = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
    end else begin
      state    <= state_nx;
      baud_cnt <= baud_nx;
      bit_idx  <= bit_nx;
      shift    <= shift_nx;
    end
  end

  // Each bit lasts div cycles; the counter reloads from the live divisor
  // at every bit boundary, so divisor writes apply from the next bit.
  assign bit_end = (baud_cnt == 16'd0);

  always_comb begin
    state_nx = state;
    baud_nx  = baud_cnt;
    bit_nx   = bit_idx;
    shift_nx = shift;
    pop      = 1'b0;
    tx       = 1'b1;
    case (state)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop      = 1'b1;
          shift_nx = fifo_dout;
          baud_nx  = div - 16'd1;
          state_nx = S_START;
        end
      end
      S_START: begin
        tx = 1'b0;
        if (bit_end) begin
          baud_nx  = div - 16'd1;
          bit_nx   = 3'd0;
          state_nx = S_DATA;
        end else begin
          baud_nx = baud_cnt - 16'd1;
        end
      end
      S_DATA: begin
        tx = shift[0];
        if (bit_end) begin
          baud_nx  = div - 16'd1;
          shift_nx = {1'b0, shift[7:1]};
          if (bit_idx == 3'd7) state_nx = S_STOP;
          else                 bit_nx   = bit_idx + 3'd1;
        end else begin
          baud_nx = baud_cnt - 16'd1;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (!fifo_empty) begin
            pop      = 1'b1;
            shift_nx = fifo_dout;
            baud_nx  = div - 16'd1;
            state_nx = S_START;
          end else begin
            state_nx = S_IDLE;
          end
        end else begin
          baud_nx = baud_cnt - 16'd1;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Scoreboard bench: the driver queues each expected frame (byte plus bit
// durations); a line monitor decodes tx and checks every cycle of each bit.
module tb_mmio_uart_tx;
  import uart_pkg::*;

  localparam logic [31:0] BASE = 32'h1000_0000;
  localparam logic [31:0] DEF_DIV = 32'd868;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] data_addr = '0;
  logic [31:0] data_wdata = '0;
  logic [3:0]  data_we = '0;
  logic [31:0] data_rdata;
  logic        hit;
  logic        tx;

  mmio_uart_tx #(.BASE_ADDR(BASE), .FIFO_DEPTH(4), .DEFAULT_DIV(16'd868)) dut (
    .clk        (clk),
    .rst        (rst),
    .data_addr  (data_addr),
    .data_wdata (data_wdata),
    .data_we    (data_we),
    .data_rdata (data_rdata),
    .hit        (hit),
    .tx         (tx)
  );

  always #5 clk = ~clk;

  // Bits below n_a last d_a cycles, the rest d_b (models a mid-frame divisor change).
  typedef struct {
    logic [7:0] data;
    int         d_a;
    int         d_b;
    int         n_a;
  } frame_t;

  frame_t  exp_q[$];
  longint  starts[$];
  longint  cyc = 0;
  bit      in_frame = 1'b0;
  int      n_chk = 0;
  int      n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Line monitor: each falling edge on an idle line must match the next queued frame.
  initial begin
    frame_t f;
    logic   eb;
    bit     ok, abort;
    int     blen;
    forever begin
      @(negedge clk);
      if (rst !== 1'b0) continue;
      if (tx === 1'b0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_start", {31'd0, tx}, 32'd1);
          for (int k = 0; k < 2000 && tx === 1'b0; k++) @(negedge clk);
        end else begin
          f = exp_q.pop_front();
          starts.push_back(cyc);
          in_frame = 1'b1;
          abort = 1'b0;
          for (int b = 0; b < 10 && !abort; b++) begin
            eb   = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : f.data[b-1];
            blen = (b < f.n_a) ? f.d_a : f.d_b;
            ok   = 1'b1;
            for (int c = 0; c < blen; c++) begin
              if (b > 0 || c > 0) @(negedge clk);
              if (rst !== 1'b0) begin abort = 1'b1; break; end
              if (tx !== eb) ok = 1'b0;
            end
            if (!abort) check($sformatf("frame_%02h_bit%0d", f.data, b), {31'd0, ok}, 32'd1);
          end
          in_frame = 1'b0;
        end
      end
    end
  end

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] we);
    @(negedge clk);
    data_addr = a; data_wdata = d; data_we = we;
    @(posedge clk);
    #1;
    data_we = 4'd0; data_addr = 32'd0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    data_addr = a; data_we = 4'd0;
    #1;
    d = data_rdata;
    data_addr = 32'd0;
  endtask

  task automatic send(input logic [7:0] b, input int d_a, input int d_b, input int n_a);
    frame_t f;
    f.data = b; f.d_a = d_a; f.d_b = d_b; f.n_a = n_a;
    exp_q.push_back(f);
    wr(BASE + {28'd0, OFF_TXDATA}, {24'd0, b}, 4'b0001);
  endtask

  task automatic wait_idle(input int limit);
    logic [31:0] st;
    bit done;
    done = 1'b0;
    for (int i = 0; i < limit && !done; i++) begin
      @(posedge clk); #2;
      rd(BASE + {28'd0, OFF_STATUS}, st);
      if (!st[ST_BUSY] && st[ST_EMPTY] && !in_frame) done = 1'b1;
    end
    if (!done) check("idle_timeout", st, 32'h4);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
    $fatal(1);
  end

  initial begin
    logic [31:0] r;
    logic [7:0]  b;
    int          d, nb;
    longint      s0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_tx", {31'd0, tx}, 32'd1);
    rd(BASE + 32'h4, r); check("reset_status", r, 32'h4);
    rd(BASE + 32'h8, r); check("reset_div", r, DEF_DIV);
    @(negedge clk) rst = 1'b0;

    // Single byte at div 4: busy drops exactly 41 edges after the write
    wr(BASE + 32'h8, 32'd4, 4'b0011);
    rd(BASE + 32'h8, r); check("div4", r, 32'd4);
    send(8'hA5, 4, 4, 10);
    repeat (40) @(posedge clk);
    #1; rd(BASE + 32'h4, r); check("a5_busy_n40", r, 32'h5);
    @(posedge clk);
    #1; rd(BASE + 32'h4, r); check("a5_idle_n41", r, 32'h4);
    wait_idle(200);

    // Back-to-back frames at div 2
    wr(BASE + 32'h8, 32'd2, 4'b0001);
    s0 = starts.size();
    send(8'h01, 2, 2, 10);
    send(8'h02, 2, 2, 10);
    send(8'h03, 2, 2, 10);
    repeat (38) @(posedge clk);
    #1; rd(BASE + 32'h4, r); check("b2b_empty_before", {31'd0, r[ST_EMPTY]}, 32'd0);
    @(posedge clk);
    #1; rd(BASE + 32'h4, r); check("b2b_empty_after", {31'd0, r[ST_EMPTY]}, 32'd1);
    wait_idle(200);
    check("b2b_count", starts.size() - s0, 32'd3);
    if (starts.size() - s0 == 3) begin
      check("b2b_gap1", starts[s0+1] - starts[s0], 32'd20);
      check("b2b_gap2", starts[s0+2] - starts[s0+1], 32'd20);
    end

    // Divisor 0 is stored as 1
    wr(BASE + 32'h8, 32'd0, 4'b0011);
    rd(BASE + 32'h8, r); check("div0_reads1", r, 32'd1);
    send(8'($urandom), 1, 1, 10);
    wait_idle(100);

    // Divisor 4 -> 8 written during data bit 2
    wr(BASE + 32'h8, 32'd4, 4'b0011);
    send(8'($urandom), 4, 8, 4);
    repeat (13) @(posedge clk);
    wr(BASE + 32'h8, 32'd8, 4'b0001);
    rd(BASE + 32'h8, r); check("div8", r, 32'd8);
    wait_idle(200);

    // Randomized short bursts
    for (int it = 0; it < 6; it++) begin
      d  = $urandom_range(1, 6);
      nb = $urandom_range(1, 3);
      wr(BASE + 32'h8, 32'(d), 4'b0011);
      for (int k = 0; k < nb; k++) begin
        b = 8'($urandom);
        send(b, d, d, 10);
        repeat ($urandom_range(0, 3)) @(posedge clk);
      end
      wait_idle(500);
    end

    // Overflow: one byte popped, four queued, sixth dropped
    wr(BASE + 32'h8, 32'd100, 4'b0001);
    for (int k = 0; k < 5; k++) send(8'($urandom), 100, 100, 10);
    wr(BASE, 32'($urandom) & 32'hFF, 4'b0001);
    rd(BASE + 32'h4, r); check("ovf_status", r, 32'hB);
    wr(BASE + 32'h4, 32'h8, 4'b0001);
    rd(BASE + 32'h4, r); check("ovf_cleared", r, 32'h3);
    wait_idle(6000);
    rd(BASE + 32'h4, r); check("ovf_drained", r, 32'h4);

    // Decode: out-of-window, unmapped offset, wrong lane
    data_addr = BASE + 32'h10; #1;
    check("hit_outside", {31'd0, hit}, 32'd0);
    check("rdata_outside", data_rdata, 32'd0);
    data_addr = BASE + 32'h4; #1;
    check("hit_inside", {31'd0, hit}, 32'd1);
    wr(BASE + 32'h10, 32'h55, 4'hF);
    wr(BASE + 32'hC, 32'h66, 4'hF);
    rd(BASE + 32'hC, r); check("rdata_offC", r, 32'd0);
    wr(BASE, 32'h77, 4'b0010);
    rd(BASE, r); check("rdata_txdata", r, 32'd0);
    repeat (5) @(posedge clk);
    #1; rd(BASE + 32'h4, r); check("decode_no_push", r, 32'h4);

    // Reset mid-frame
    wr(BASE + 32'h8, 32'd4, 4'b0011);
    send(8'($urandom), 4, 4, 10);
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    #1 check("midrst_tx", {31'd0, tx}, 32'd1);
    rd(BASE + 32'h4, r); check("midrst_status", r, 32'h4);
    rd(BASE + 32'h8, r); check("midrst_div", r, DEF_DIV);
    @(negedge clk);
    @(negedge clk);
    exp_q.delete();
    rst = 1'b0;
    wr(BASE + 32'h8, 32'd3, 4'b0011);
    send(8'($urandom), 3, 3, 10);
    wait_idle(200);

    repeat (20) @(posedge clk);
    check("frames_pending", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
